mem_burst_ctrl: RTL
===================

# mem_burst_ctrl

Burst access sequencer placed directly upstream of the 32x256 single-port `memory` block; it owns that block's `addr`/`wdata`/`wrbar` inputs and consumes its `rdata`. It accepts one burst command at a time, streams write data in through a valid/ready handshake, generates consecutive wrapping addresses, and returns read data as a valid-qualified stream. A one-cycle `done` pulse ends every burst.

## Interface
- `WIDTH`, 32, data word width; must match memory.
- `DEPTH`, 256, memory words; must equal 2**ADDR.
- `ADDR`, 8, address width.
- `RD_LAT`, 1, memory cycles from sampled `addr` to valid `rdata`; legal 1..4.

- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: high only in IDLE.
- `cmd_op` input 1: 1 = write burst, 0 = read burst.
- `cmd_addr` input ADDR: start address.
- `cmd_len` input ADDR: beats minus one (0 gives 1 beat, 255 gives 256).
- `wr_valid` input 1: write beat offered.
- `wr_ready` output 1: write beat accepted this cycle.
- `wr_data` input WIDTH: write beat data.
- `rd_valid` output 1: `rd_data` valid this cycle; no backpressure.
- `rd_data` output WIDTH: read beat data.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at burst completion.
- `mem_addr` output ADDR: to memory `addr`.
- `mem_wdata` output WIDTH: to memory `wdata`.
- `mem_wrbar` output 1: to memory `wrbar`; 1 = write, 0 = read.
- `mem_rdata` input WIDTH: from memory `rdata`.

## Operation
- FSM states are IDLE, WRITE, READ, DRAIN and DONE.
- **IDLE**: `cmd_ready`=1. A `cmd_valid` handshake latches addr, len and op into internal regs and sets the beat counter to `cmd_len`. Next state is WRITE if `cmd_op`=1, else READ.
- **WRITE**: `wr_ready`=1.
  - Each `wr_valid` handshake registers `mem_addr`=current addr, `mem_wdata`=`wr_data` and `mem_wrbar`=1, then increments addr.
  - A cycle without `wr_valid` registers `mem_wrbar`=0, so no write occurs and a gap is legal.
  - After the last beat (counter 0), go to DONE.
- **READ**: one address issued per cycle: `mem_addr`=addr, `mem_wrbar`=0, addr incremented. Each issue shifts a 1 into a RD_LAT+1 deep issue pipeline. After the last issue, go to DRAIN.
- **DRAIN**: hold `mem_wrbar`=0 until the issue pipeline is empty, then go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- Read return: when the issue pipeline output is 1, `rd_data`<=`mem_rdata` and `rd_valid`<=1; otherwise `rd_valid`<=0. Return is active in READ and DRAIN only.
- Addresses increment modulo DEPTH (natural ADDR-bit wrap); 0xFF is followed by 0x00.
- `cmd_valid` outside IDLE is ignored; it is not queued.
- Outside WRITE, `mem_wrbar` is always 0 and `mem_wdata` holds its last value.

## Timing
- Reset values (async, on `rst`=0): state IDLE, `cmd_ready`=1, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `done`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wrbar`=0, issue pipeline cleared.
- A command accepted at edge k puts the block in WRITE or READ from cycle k+1.
- Write: a beat accepted at edge n appears on the memory pins after edge n. The memory writes it at edge n+1.
- Read: an address registered at edge n gives `rd_valid` high after edge n+1+RD_LAT. A burst of L beats returns L consecutive `rd_valid` cycles.
- Total read burst length, acceptance to `done`: 1 + L + (RD_LAT+1) + 1 cycles.
- A write burst with no gaps asserts `done` in cycle k+L+1.
- Reset mid-burst: the burst is abandoned immediately and in-flight reads are dropped (`rd_valid`=0). Memory contents already written stay. `mem_wrbar`=0 guarantees no stray write.
- `done` and `cmd_ready` are never high in the same cycle; the next command is accepted at the earliest one cycle after `done`.

## Test plan
- Write burst at addr 0xFC, len 3, data 0xA0..0xA3 with no gaps: `mem_wrbar`=1 for 4 cycles on addrs FC, FD, FE, FF, then `done`. Memory holds the data.
- Read burst at 0xFE, len 3 (wraps): 4 `rd_valid` beats return data from FE, FF, 00, 01 in order, with a first-beat latency of RD_LAT+1 after the first issue.
- Write with `wr_valid` toggled every other cycle, 3 beats: only handshaked cycles show `mem_wrbar`=1, addresses are consecutive, and `done` follows the third beat.
- Full-memory write then read with len 255 and `$random` data: all 256 read beats match the written data and addresses wrap back to start.
- `rst` pulled low mid-way through an 8-beat read: all outputs go to reset values asynchronously, no further `rd_valid` appears, and a new command is accepted after release.
- `cmd_valid` held high during a burst with different parameters: it is ignored until `done`, then accepted in the following IDLE cycle.

Source files
------------

// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst access sequencer in front of a single-port memory
//
// Accepts one read or write burst command at a time. It drives the memory's
// addr/wdata/wrbar pins from registers, and it returns read data as a
// valid-qualified stream. A one-cycle done pulse closes every burst.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only while idle)
//   cmd_op                    1 = write burst, 0 = read burst
//   cmd_addr, cmd_len         start address, beats minus one
//   wr_valid/wr_ready/wr_data write beat stream
//   rd_valid/rd_data          read beat stream, no backpressure
//   busy, done                not idle; one-cycle end-of-burst pulse
//   mem_addr/mem_wdata        registered memory address / write data
//   mem_wrbar                 registered memory write strobe (1 = write)
//   mem_rdata                 memory read data, RD_LAT cycles after sampled addr
module mem_burst_ctrl #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR   = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [ADDR-1:0]  cmd_addr,
  input  logic [ADDR-1:0]  cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_wrbar,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR-1:0] LAST_ADDR = ADDR'(DEPTH - 1);

  state_t          state;
  state_t          state_nxt;
  logic [ADDR-1:0] addr_q;
  logic [ADDR-1:0] cnt_q;
  logic [ADDR-1:0] addr_inc;
  logic [RD_LAT:0] issue_pipe;
  logic            cmd_fire;
  logic            wr_fire;
  logic            rd_issue;
  logic            last_beat;
  logic            pipe_tail_empty;

  // Burst addresses wrap from the top word back to word 0.
  assign addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR'(1);
  assign last_beat = (cnt_q == '0);
  // In DRAIN, once nothing is left behind the output stage, the read being
  // returned this cycle is the last one.
  assign pipe_tail_empty = ~|issue_pipe[RD_LAT-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    cmd_fire  = 1'b0;
    wr_fire   = 1'b0;
    rd_issue  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cmd_fire  = 1'b1;
          state_nxt = cmd_op ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          wr_fire = 1'b1;
          if (last_beat) state_nxt = S_DONE;
        end
      end
      S_READ: begin
        rd_issue = 1'b1;
        if (last_beat) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (pipe_tail_empty) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/count bookkeeping and memory pins. mem_wrbar defaults low every
  // cycle so only a handshaked write beat can strobe the memory; mem_wdata
  // holds between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wrbar <= 1'b0;
    end else begin
      mem_wrbar <= 1'b0;
      if (cmd_fire) begin
        addr_q <= cmd_addr;
        cnt_q  <= cmd_len;
      end
      if (wr_fire) begin
        mem_addr  <= addr_q;
        mem_wdata <= wr_data;
        mem_wrbar <= 1'b1;
        addr_q    <= addr_inc;
        cnt_q     <= cnt_q - ADDR'(1);
      end
      if (rd_issue) begin
        mem_addr <= addr_q;
        addr_q   <= addr_inc;
        cnt_q    <= cnt_q - ADDR'(1);
      end
    end
  end

  // One bit per issued read travels RD_LAT+1 stages: one for the address
  // register, RD_LAT for the memory. The bit leaving the last stage marks the
  // cycle in which mem_rdata belongs to that read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_pipe <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      issue_pipe <= {issue_pipe[RD_LAT-1:0], rd_issue};
      rd_valid   <= 1'b0;
      if ((state == S_READ || state == S_DRAIN) && issue_pipe[RD_LAT]) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_rdata;
      end
    end
  end

endmodule
